// File: rtl/read_mem_arbiter.sv
// Two-requester (fetch/load) arbiter onto one memory read port, one read in flight.
// Define READ_MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is load-over-fetch priority.
module read_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int ADDR_START = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             fetch_req_valid,
  input  logic [ADDR_WIDTH-1:ADDR_START]   fetch_req_addr,
  output logic                             fetch_req_ready,
  output logic                             fetch_resp_valid,
  output logic [DATA_WIDTH-1:0]            fetch_resp_data,
  input  logic                             load_req_valid,
  input  logic [ADDR_WIDTH-1:ADDR_START]   load_req_addr,
  output logic                             load_req_ready,
  output logic                             load_resp_valid,
  output logic [DATA_WIDTH-1:0]            load_resp_data,
  output logic                             mem_req_valid,
  output logic [ADDR_WIDTH-1:ADDR_START]   mem_req_addr,
  input  logic                             mem_req_ready,
  input  logic                             mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]            mem_resp_data,
  output logic                             busy,
  output logic                             spurious_resp
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic OWNER_FETCH = 1'b0;
  localparam logic OWNER_LOAD  = 1'b1;

  state_t                           state_q;
  logic [ADDR_WIDTH-1:ADDR_START]   addr_q;
  logic                             owner_q;
  logic                             spurious_q;
  logic                             spurious_d;
  logic                             in_idle;
  logic                             grant_load;
  logic                             grant_fetch;

`ifdef READ_MEM_ARB_ROUND_ROBIN_EN
  logic last_q;
  // Under contention the side that did not win last time gets the port.
  assign grant_load = load_req_valid && (!fetch_req_valid || (last_q == OWNER_FETCH));
`else
  assign grant_load = load_req_valid;
`endif
  assign grant_fetch = fetch_req_valid && !grant_load;

  // Ready is combinational, so it must also be masked while reset is held.
  assign in_idle = rst && (state_q == IDLE);

  assign fetch_req_ready = in_idle && grant_fetch;
  assign load_req_ready  = in_idle && grant_load;

  assign mem_req_valid = (state_q == ISSUE);
  assign mem_req_addr  = addr_q;
  assign busy          = (state_q != IDLE);
  assign spurious_resp = spurious_q;

  assign fetch_resp_valid = (state_q == WAIT) && mem_resp_valid && (owner_q == OWNER_FETCH);
  assign load_resp_valid  = (state_q == WAIT) && mem_resp_valid && (owner_q == OWNER_LOAD);
  assign fetch_resp_data  = mem_resp_data;
  assign load_resp_data   = mem_resp_data;

  assign spurious_d = spurious_q || (mem_resp_valid && (state_q != WAIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      owner_q    <= OWNER_FETCH;
      spurious_q <= 1'b0;
`ifdef READ_MEM_ARB_ROUND_ROBIN_EN
      last_q     <= OWNER_FETCH;
`endif
    end else begin
      spurious_q <= spurious_d;
      case (state_q)
        IDLE: begin
          if (grant_load || grant_fetch) begin
            state_q <= ISSUE;
            addr_q  <= grant_load ? load_req_addr : fetch_req_addr;
            owner_q <= grant_load ? OWNER_LOAD : OWNER_FETCH;
`ifdef READ_MEM_ARB_ROUND_ROBIN_EN
            last_q  <= grant_load ? OWNER_LOAD : OWNER_FETCH;
`endif
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_read_mem_arbiter.sv
// Self-checking bench for read_mem_arbiter: directed scenarios plus a randomized run
// against a transaction-level model (pending request, in-flight read, sticky error flag).
module tb_read_mem_arbiter;

  localparam int AW = 32;
  localparam int AS = 2;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          fetch_req_valid;
  logic [AW-1:AS] fetch_req_addr;
  logic          fetch_req_ready;
  logic          fetch_resp_valid;
  logic [DW-1:0] fetch_resp_data;
  logic          load_req_valid;
  logic [AW-1:AS] load_req_addr;
  logic          load_req_ready;
  logic          load_resp_valid;
  logic [DW-1:0] load_resp_data;
  logic          mem_req_valid;
  logic [AW-1:AS] mem_req_addr;
  logic          mem_req_ready;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_data;
  logic          busy;
  logic          spurious_resp;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  read_mem_arbiter #(.ADDR_WIDTH(AW), .ADDR_START(AS), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .fetch_req_valid(fetch_req_valid), .fetch_req_addr(fetch_req_addr),
    .fetch_req_ready(fetch_req_ready), .fetch_resp_valid(fetch_resp_valid),
    .fetch_resp_data(fetch_resp_data),
    .load_req_valid(load_req_valid), .load_req_addr(load_req_addr),
    .load_req_ready(load_req_ready), .load_resp_valid(load_resp_valid),
    .load_resp_data(load_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data),
    .busy(busy), .spurious_resp(spurious_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    fetch_req_valid = 1'b0;
    fetch_req_addr  = '0;
    load_req_valid  = 1'b0;
    load_req_addr   = '0;
    mem_req_ready   = 1'b0;
    mem_resp_valid  = 1'b0;
    mem_resp_data   = '0;
  endtask

  // Leaves the bench at posedge+1 with rst just released; the next edge may grant.
  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    fetch_req_valid = 1'b1;
    load_req_valid  = 1'b1;
    mem_resp_valid  = 1'b1;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({busy, spurious_resp, mem_req_valid, fetch_req_ready, load_req_ready,
         fetch_resp_valid, load_resp_valid} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 0000000",
               {busy, spurious_resp, mem_req_valid, fetch_req_ready, load_req_ready,
                fetch_resp_valid, load_resp_valid});
    end
    n_checks++;
    if (mem_req_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_addr: got %h required 0", mem_req_addr);
    end
    do_reset();
    $display("test_reset done");
  endtask

  task automatic test_single_fetch();
    do_reset();
    fetch_req_valid = 1'b1;
    fetch_req_addr  = 30'h40;
    mem_req_ready   = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({fetch_req_ready, load_req_ready, mem_req_valid, busy} !== 4'b1000) begin
      n_fail++;
      $display("FAIL single_c1: rdyF/rdyL/mv/busy got %b required 1000",
               {fetch_req_ready, load_req_ready, mem_req_valid, busy});
    end
    next_cycle();
    fetch_req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (!(mem_req_valid === 1'b1 && mem_req_addr === 30'h40 && busy === 1'b1)) begin
      n_fail++;
      $display("FAIL single_c2: mv=%b addr=%h busy=%b required 1 40 1",
               mem_req_valid, mem_req_addr, busy);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({mem_req_valid, busy, fetch_resp_valid} !== 3'b010) begin
      n_fail++;
      $display("FAIL single_c3: mv/busy/rv got %b required 010",
               {mem_req_valid, busy, fetch_resp_valid});
    end
    next_cycle();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hDEADBEEF;
    @(negedge clk);
    n_checks++;
    if (!(fetch_resp_valid === 1'b1 && fetch_resp_data === 32'hDEADBEEF &&
          load_resp_valid === 1'b0 && busy === 1'b1)) begin
      n_fail++;
      $display("FAIL single_c4: frv=%b data=%h lrv=%b busy=%b required 1 deadbeef 0 1",
               fetch_resp_valid, fetch_resp_data, load_resp_valid, busy);
    end
    $display("txn fetch addr=%h data=%h", 30'h40, 32'hDEADBEEF);
    next_cycle();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, spurious_resp} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_c5: busy/spur got %b required 00", {busy, spurious_resp});
    end
  endtask

  task automatic test_contention();
    bit grants[$];
    int grant_cycle[$];
    bit exp_seq[4];
`ifdef READ_MEM_ARB_ROUND_ROBIN_EN
    exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    do_reset();
    fetch_req_valid = 1'b1;
    fetch_req_addr  = 30'h111;
    load_req_valid  = 1'b1;
    load_req_addr   = 30'h222;
    mem_req_ready   = 1'b1;
    for (int cyc = 0; cyc < 40 && grants.size() < 4; cyc++) begin
      // Responsive memory: answer the cycle after the request handshake.
      mem_resp_valid = busy && !mem_req_valid;
      mem_resp_data  = 32'hC0DE0000 + 32'(cyc);
      @(negedge clk);
      if (fetch_req_ready === 1'b1 && load_req_ready === 1'b1) begin
        n_checks++;
        n_fail++;
        $display("FAIL contention_both_ready: cycle %0d both readies 1 required one", cyc);
      end
      if (load_req_ready === 1'b1 || fetch_req_ready === 1'b1) begin
        grants.push_back(load_req_ready);
        grant_cycle.push_back(cyc);
        $display("txn grant %s at cycle %0d", load_req_ready ? "load" : "fetch", cyc);
      end
      next_cycle();
    end
    mem_resp_valid  = 1'b0;
    fetch_req_valid = 1'b0;
    load_req_valid  = 1'b0;
    n_checks++;
    if (grants.size() != 4) begin
      n_fail++;
      $display("FAIL contention_count: got %0d grants required 4", grants.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (grants[i] !== exp_seq[i]) begin
          n_fail++;
          $display("FAIL contention_grant%0d: got load=%b required load=%b",
                   i, grants[i], exp_seq[i]);
        end
      end
      for (int i = 1; i < 4; i++) begin
        n_checks++;
        if (grant_cycle[i] - grant_cycle[i-1] < 3) begin
          n_fail++;
          $display("FAIL contention_period%0d: got %0d cycles required >=3",
                   i, grant_cycle[i] - grant_cycle[i-1]);
        end
      end
    end
    next_cycle();
    next_cycle();
  endtask

  task automatic test_backpressure();
    do_reset();
    load_req_valid = 1'b1;
    load_req_addr  = 30'h1234;
    mem_req_ready  = 1'b0;
    @(negedge clk);
    n_checks++;
    if (load_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_grant: load_ready got %b required 1", load_req_ready);
    end
    next_cycle();
    fetch_req_valid = 1'b1;
    load_req_addr   = 30'h2BAD;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (!(mem_req_valid === 1'b1 && mem_req_addr === 30'h1234 &&
            fetch_req_ready === 1'b0 && load_req_ready === 1'b0)) begin
        n_fail++;
        $display("FAIL bp_hold%0d: mv=%b addr=%h rdyF=%b rdyL=%b required 1 1234 0 0",
                 i, mem_req_valid, mem_req_addr, fetch_req_ready, load_req_ready);
      end
      next_cycle();
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_req_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: mv got %b required 1", mem_req_valid);
    end
    next_cycle();
    mem_req_ready   = 1'b0;
    fetch_req_valid = 1'b0;
    load_req_valid  = 1'b0;
    mem_resp_valid  = 1'b1;
    mem_resp_data   = 32'h5A5A1234;
    @(negedge clk);
    n_checks++;
    if (!(load_resp_valid === 1'b1 && load_resp_data === 32'h5A5A1234 &&
          fetch_resp_valid === 1'b0)) begin
      n_fail++;
      $display("FAIL bp_resp: lrv=%b data=%h frv=%b required 1 5a5a1234 0",
               load_resp_valid, load_resp_data, fetch_resp_valid);
    end
    $display("txn load addr=%h data=%h", 30'h1234, 32'h5A5A1234);
    next_cycle();
    mem_resp_valid = 1'b0;
  endtask

  task automatic test_spurious();
    do_reset();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0BADF00D;
    @(negedge clk);
    n_checks++;
    if ({fetch_resp_valid, load_resp_valid, spurious_resp} !== 3'b000) begin
      n_fail++;
      $display("FAIL spur_forward: frv/lrv/spur got %b required 000",
               {fetch_resp_valid, load_resp_valid, spurious_resp});
    end
    next_cycle();
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (spurious_resp !== 1'b1) begin
        n_fail++;
        $display("FAIL spur_sticky%0d: got %b required 1", i, spurious_resp);
      end
      next_cycle();
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (spurious_resp !== 1'b0) begin
      n_fail++;
      $display("FAIL spur_clear: got %b required 0", spurious_resp);
    end
    do_reset();
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    load_req_valid = 1'b1;
    load_req_addr  = 30'h55;
    mem_req_ready  = 1'b1;
    @(negedge clk);
    next_cycle();
    load_req_valid = 1'b0;
    next_cycle();
    n_checks++;
    if (!(busy === 1'b1 && mem_req_valid === 1'b0)) begin
      n_fail++;
      $display("FAIL rstwait_setup: busy=%b mv=%b required 1 0", busy, mem_req_valid);
    end
    load_req_valid = 1'b1;
    load_req_addr  = 30'h77;
    mem_resp_valid = 1'b1;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({busy, spurious_resp, mem_req_valid, load_req_ready, fetch_req_ready,
         load_resp_valid, fetch_resp_valid} !== 7'b0 || mem_req_addr !== '0) begin
      n_fail++;
      $display("FAIL rstwait_outputs: got %b addr=%h required 0000000 0",
               {busy, spurious_resp, mem_req_valid, load_req_ready, fetch_req_ready,
                load_resp_valid, fetch_resp_valid}, mem_req_addr);
    end
    next_cycle();
    mem_resp_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (load_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstwait_grant: load_ready got %b required 1", load_req_ready);
    end
    next_cycle();
    load_req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (!(mem_req_valid === 1'b1 && mem_req_addr === 30'h77)) begin
      n_fail++;
      $display("FAIL rstwait_issue: mv=%b addr=%h required 1 77", mem_req_valid, mem_req_addr);
    end
    next_cycle();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h77777777;
    @(negedge clk);
    n_checks++;
    if (load_resp_valid !== 1'b1 || spurious_resp !== 1'b0) begin
      n_fail++;
      $display("FAIL rstwait_resp: lrv=%b spur=%b required 1 0", load_resp_valid, spurious_resp);
    end
    $display("txn load addr=%h data=%h", 30'h77, 32'h77777777);
    next_cycle();
    mem_resp_valid = 1'b0;
  endtask

  // Model: a granted request is "pending" until the memory takes it, then "in flight"
  // until a response arrives; a response with nothing in flight is an error.
  task automatic test_random();
    bit             pend, infl, pend_owner, infl_owner, spur, last;
    logic [AW-1:AS] pend_addr, infl_addr;
    bit             exp_gl, exp_gf, idle;
    do_reset();
    pend = 0; infl = 0; spur = 0; last = 0; pend_owner = 0; infl_owner = 0;
    pend_addr = '0; infl_addr = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      fetch_req_valid = ($urandom_range(0, 1) == 1);
      load_req_valid  = ($urandom_range(0, 2) == 0);
      fetch_req_addr  = AW'($urandom) >> AS;
      load_req_addr   = AW'($urandom) >> AS;
      mem_req_ready   = ($urandom_range(0, 4) < 3);
      mem_resp_valid  = infl ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 99) == 0);
      mem_resp_data   = $urandom;
      @(negedge clk);
      idle = !pend && !infl;
`ifdef READ_MEM_ARB_ROUND_ROBIN_EN
      exp_gl = idle && load_req_valid && (!fetch_req_valid || last == 1'b0);
`else
      exp_gl = idle && load_req_valid;
`endif
      exp_gf = idle && fetch_req_valid && !exp_gl;
      n_checks++;
      if ({load_req_ready, fetch_req_ready} !== {exp_gl, exp_gf}) begin
        n_fail++;
        $display("FAIL rnd_ready c%0d: L/F got %b%b required %b%b",
                 cyc, load_req_ready, fetch_req_ready, exp_gl, exp_gf);
      end
      n_checks++;
      if (mem_req_valid !== pend || (pend && mem_req_addr !== pend_addr)) begin
        n_fail++;
        $display("FAIL rnd_memreq c%0d: mv=%b addr=%h required %b %h",
                 cyc, mem_req_valid, mem_req_addr, pend, pend_addr);
      end
      n_checks++;
      if ({load_resp_valid, fetch_resp_valid} !==
          {infl && mem_resp_valid && infl_owner, infl && mem_resp_valid && !infl_owner}) begin
        n_fail++;
        $display("FAIL rnd_resp c%0d: L/F got %b%b", cyc, load_resp_valid, fetch_resp_valid);
      end
      n_checks++;
      if (load_resp_data !== mem_resp_data || fetch_resp_data !== mem_resp_data) begin
        n_fail++;
        $display("FAIL rnd_data c%0d: L=%h F=%h required %h",
                 cyc, load_resp_data, fetch_resp_data, mem_resp_data);
      end
      n_checks++;
      if (busy !== !idle || spurious_resp !== spur) begin
        n_fail++;
        $display("FAIL rnd_status c%0d: busy=%b spur=%b required %b %b",
                 cyc, busy, spurious_resp, !idle, spur);
      end
      if (mem_resp_valid && !infl) spur = 1;
      if (exp_gl || exp_gf) begin
        pend = 1; pend_owner = exp_gl; last = exp_gl;
        pend_addr = exp_gl ? load_req_addr : fetch_req_addr;
      end else if (pend && mem_req_ready) begin
        pend = 0; infl = 1; infl_owner = pend_owner; infl_addr = pend_addr;
      end else if (infl && mem_resp_valid) begin
        infl = 0;
        n_txn++;
        $display("txn %0d %s addr=%h data=%h", n_txn, infl_owner ? "load" : "fetch",
                 infl_addr, mem_resp_data);
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    test_reset();
    test_single_fetch();
    test_contention();
    test_backpressure();
    test_spurious();
    test_reset_in_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/read_mem_arbiter.md
READ_MEM_ARBITER -- requirements
Module: read_mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 Parameter ADDR_START, default 2, lowest carried address bit (4-byte aligned words).
REQ-003 Parameter DATA_WIDTH, default 32, read data width.
REQ-004 Port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  in  1  asynchronous reset, active-low.
REQ-006 Ports fetch_req_valid in 1, fetch_req_addr in [ADDR_WIDTH-1:ADDR_START], fetch_req_ready out 1: instruction-fetch read request.
REQ-007 Ports fetch_resp_valid out 1, fetch_resp_data out DATA_WIDTH: fetch read response.
REQ-008 Ports load_req_valid in 1, load_req_addr in [ADDR_WIDTH-1:ADDR_START], load_req_ready out 1: load read request.
REQ-009 Ports load_resp_valid out 1, load_resp_data out DATA_WIDTH: load read response.
REQ-010 Ports mem_req_valid out 1, mem_req_addr out [ADDR_WIDTH-1:ADDR_START], mem_req_ready in 1: shared memory read port request.
REQ-011 Ports mem_resp_valid in 1, mem_resp_data in DATA_WIDTH: shared memory read response.
REQ-012 Ports busy out 1 (state != IDLE); spurious_resp out 1 (sticky error flag).

Function
REQ-013 FSM states IDLE, ISSUE, WAIT; at most one memory read outstanding.
REQ-014 IDLE: if any req_valid, grant exactly one requester; its req_ready = 1 combinationally that cycle; latch its address and owner id; next state ISSUE.
REQ-015 req_ready of both requesters = 0 in ISSUE and WAIT, and in IDLE for the non-granted requester.
REQ-016 ISSUE: mem_req_valid = 1, mem_req_addr = latched address, both held stable until mem_req_ready = 1; on handshake next state WAIT.
REQ-017 Latency: request accepted in cycle N -> mem_req_valid first asserted in cycle N+1.
REQ-018 WAIT: when mem_resp_valid = 1, owner's resp_valid = 1 and resp_data = mem_resp_data in that same cycle (combinational forward); next state IDLE.
REQ-019 Non-owner resp_valid = 0 always; resp_data of both requesters = mem_resp_data (qualified only by valid).
REQ-020 A new request is accepted no earlier than the cycle after the response cycle (minimum 3-cycle request-to-request period).
REQ-021 mem_resp_valid = 1 in IDLE or ISSUE is ignored (not forwarded) and sets spurious_resp = 1 until reset.
REQ-022 Default arbitration: fixed priority, load over fetch.
REQ-023 mem_resp_valid and mem_req_ready are ignored in states where they carry no meaning except as REQ-021 states.

Reset
REQ-024 rst = 0 asynchronously forces state IDLE; busy, spurious_resp, mem_req_valid, mem_req_addr, latched address and owner = 0; req_ready and resp_valid = 0 while rst = 0.
REQ-025 Reset mid-ISSUE or mid-WAIT abandons the outstanding read; a response arriving after reset release while IDLE sets spurious_resp.
REQ-026 First grant possible in the first rising edge with rst = 1.

Configuration
REQ-027 Macro READ_MEM_ARB_ROUND_ROBIN_EN defined: round-robin arbitration; 1-bit last-grant pointer, reset value "fetch"; when both request, the requester not last granted wins; pointer updates on every grant.
REQ-028 Macro undefined: fixed priority per REQ-022; no pointer register.

Verification
REQ-029 Single fetch: fetch_req_valid=1 addr 0x100>>2 at cycle 1, mem_req_ready=1, mem_resp_valid at cycle 4 data 0xDEADBEEF -> fetch_req_ready cycle 1, mem_req_valid cycle 2 addr 0x40, fetch_resp_valid cycle 4 data 0xDEADBEEF, busy cycles 2-4.
REQ-030 Contention, macro undefined: both valid continuously, 4 transactions -> grants load,load,load,load; fetch_req_ready never 1.
REQ-031 Contention, macro defined: both valid continuously, 4 transactions -> grants load,fetch,load,fetch.
REQ-032 Backpressure: mem_req_ready=0 for 5 cycles in ISSUE -> mem_req_valid and mem_req_addr constant for all 5 cycles, no second grant.
REQ-033 Spurious: mem_resp_valid=1 in IDLE -> no resp_valid on either requester, spurious_resp=1 and held until rst=0.
REQ-034 Reset in WAIT: rst=0 for 1 cycle -> all outputs 0 immediately, state IDLE, next load request granted on first edge after release.
